axi_burst_master: RTL and testbench

// AXI4 burst initiator: turns one command (write or read, INCR burst) into full
// AW/W/B or AR/R transactions toward an AXI slave such as the PIM memory block.

---
 rtl/axi_burst_master.sv | 202 ++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 INCR burst initiator: one write (AW/W/B) or read (AR/R) command in flight.
// Write beats come from a valid/ready stream; read beats leave on a valid/ready stream.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  done_err,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_cmd_ready;
  logic                  r_awvalid;
  logic                  r_arvalid;
  logic                  r_bready;
  logic                  r_done;
  logic [1:0]            r_done_resp;
  logic                  r_done_err;

  logic w_in_w, w_in_r, w_last_beat, w_w_hs, w_r_hs;
  logic w_unused;

  assign w_in_w      = (r_state == S_W);
  assign w_in_r      = (r_state == S_R);
  assign w_last_beat = (r_cnt == r_len);
  assign w_w_hs      = w_in_w & wr_valid & m_axi_wready;
  assign w_r_hs      = w_in_r & m_axi_rvalid & rd_ready;
  // Response IDs are deliberately ignored.
  assign w_unused    = ^{m_axi_bid, m_axi_rid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_id        <= '0;
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_done      <= 1'b0;
      r_done_resp <= '0;
      r_done_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_len       <= cmd_len;
            r_id        <= cmd_id;
            r_cnt       <= '0;
            r_done_resp <= '0;
            r_done_err  <= 1'b0;
            if (cmd_write) begin
              r_state   <= S_AW;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_AW: if (m_axi_awready) begin
          r_awvalid <= 1'b0;
          r_state   <= S_W;
        end
        S_W: if (w_w_hs) begin
          r_cnt <= r_cnt + 8'd1;
          if (w_last_beat) begin
            r_state  <= S_B;
            r_bready <= 1'b1;
          end
        end
        S_B: if (m_axi_bvalid) begin
          r_bready    <= 1'b0;
          r_done_resp <= m_axi_bresp;
          r_done      <= 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_AR: if (m_axi_arready) begin
          r_arvalid <= 1'b0;
          r_state   <= S_R;
        end
        S_R: if (w_r_hs) begin
          r_cnt <= r_cnt + 8'd1;
          if (m_axi_rresp > r_done_resp) r_done_resp <= m_axi_rresp;
          if (m_axi_rlast != w_last_beat) r_done_err <= 1'b1;
          // Exit on the counted final beat whatever rlast says.
          if (w_last_beat) begin
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign wr_ready      = w_in_w & m_axi_wready;
  assign rd_data       = m_axi_rdata;
  assign rd_valid      = w_in_r & m_axi_rvalid;
  assign rd_last       = w_in_r & w_last_beat;
  assign done          = r_done;
  assign done_resp     = r_done_resp;
  assign done_err      = r_done_err;

  assign m_axi_awid    = r_id;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_len;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = '0;
  assign m_axi_awprot  = '0;
  assign m_axi_awvalid = r_awvalid;

  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = w_in_w & w_last_beat;
  assign m_axi_wvalid  = w_in_w & wr_valid;
  assign m_axi_bready  = r_bready;

  assign m_axi_arid    = r_id;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = r_len;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot  = '0;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = w_in_r & rd_ready;

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: transaction-level model plus a memory-backed AXI slave
// with random stalls; every cycle the DUT outputs are compared with the model.
module tb_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0, cmd_len = '0, cmd_id = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready = 1'b0, rd_last;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [7:0]  awid, awaddr, awlen, arid, araddr, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock, awvalid, arvalid;
  logic [3:0]  awcache, arcache, wstrb;
  logic        awready = 1'b0, arready = 1'b0, wready = 1'b0;
  logic [31:0] wdata;
  logic        wlast, wvalid, bready, rready;
  logic [7:0]  bid = '0, rid = '0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  axi_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .ID_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int n_vec = 0, n_err = 0, cyc = 0;

  // Stimulus knobs (percent probabilities) and slave fault injection
  int p_slv = 100, p_src = 100, p_sink = 100;
  logic [1:0] inj_bresp = 2'd0;
  int inj_rbeat = -1, early_last = -1;

  // Command request
  bit pend_cmd = 0, p_write = 0;
  logic [7:0] p_addr = '0, p_len = '0, p_id = '0;

  // Transaction-level model of the command in flight
  bit busy = 0, c_write = 0, a_done = 0, data_done = 0, done_due = 0, exp_err = 0;
  logic [7:0] c_addr = '0, c_id = '0;
  int c_len = 0, beats = 0;
  logic [1:0] exp_resp = '0;
  int acc_cyc = 0, done_cyc = -1;
  logic [1:0] seen_resp = '0;
  logic seen_err = 1'b0;

  // Write source, captures and memories
  logic [31:0] src_q[$];
  int src_idx = 0;
  logic [31:0] cap_w[$], cap_rd[$];
  int cap_wlast[$], cap_rlast[$];
  int cap_awlen = -1;
  logic [31:0] mem[64], ref_mem[64];

  // Slave state
  int s_wbase = 0, s_wlen = 0, s_wcnt = 0, s_rbase = 0, s_rlen = 0, s_rcnt = 0;
  bit s_bpend = 0, s_bv = 0, s_ract = 0, s_rv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit rnd(input int p);
    return $urandom_range(99, 0) < p;
  endfunction

  task automatic tick();
    bit e_aw, e_ar, e_w, e_b, e_r, was_busy;
    @(negedge clk);
    cyc++;
    cmd_valid = pend_cmd; cmd_write = p_write; cmd_addr = p_addr; cmd_len = p_len; cmd_id = p_id;
    wr_valid  = (src_idx < src_q.size()) && rnd(p_src);
    wr_data   = (src_idx < src_q.size()) ? src_q[src_idx] : $urandom;
    rd_ready  = rnd(p_sink);
    awready   = rnd(p_slv); wready = rnd(p_slv); arready = rnd(p_slv);
    if (s_bpend && !s_bv && rnd(p_slv)) s_bv = 1;
    bvalid = s_bv; bresp = inj_bresp; bid = 8'($urandom);
    if (s_ract && !s_rv && rnd(p_slv)) s_rv = 1;
    rvalid = s_rv;
    rdata  = mem[(s_rbase + s_rcnt) & 63];
    rresp  = (s_rcnt == inj_rbeat) ? 2'd2 : 2'd0;
    rlast  = (early_last >= 0) ? (s_rcnt == early_last) : (s_rcnt == s_rlen);
    rid    = 8'($urandom);
    #4;
    e_aw = busy && c_write && !a_done;
    e_w  = busy && c_write && a_done && !data_done;
    e_b  = busy && c_write && data_done;
    e_ar = busy && !c_write && !a_done;
    e_r  = busy && !c_write && a_done;
    chk("cmd_ready", cmd_ready, !busy);
    chk("done", done, done_due);
    if (done) begin done_cyc = cyc; seen_resp = done_resp; seen_err = done_err; end
    if (done_due) begin
      chk("done_resp", done_resp, exp_resp);
      chk("done_err", done_err, exp_err);
    end
    chk("awvalid", awvalid, e_aw);
    if (e_aw) begin
      chk("awaddr", awaddr, c_addr); chk("awlen", awlen, c_len); chk("awid", awid, c_id);
      chk("awsize", awsize, 2); chk("awburst", awburst, 1);
    end
    chk("arvalid", arvalid, e_ar);
    if (e_ar) begin
      chk("araddr", araddr, c_addr); chk("arlen", arlen, c_len); chk("arid", arid, c_id);
      chk("arsize", arsize, 2); chk("arburst", arburst, 1);
    end
    chk("wvalid", wvalid, e_w && wr_valid);
    chk("wr_ready", wr_ready, e_w && wready);
    chk("wlast", wlast, e_w && (beats == c_len));
    if (e_w && wr_valid) begin chk("wdata", wdata, src_q[beats]); chk("wstrb", wstrb, 4'hF); end
    chk("bready", bready, e_b);
    chk("rready", rready, e_r && rd_ready);
    chk("rd_valid", rd_valid, e_r && rvalid);
    chk("rd_last", rd_last, e_r && (beats == c_len));
    if (e_r && rvalid) chk("rd_data", rd_data, rdata);

    // Advance model and slave on the handshakes that the coming edge completes
    was_busy = busy;
    done_due = 0;
    if (e_aw && awready) begin a_done = 1; cap_awlen = awlen; end
    if (awvalid && awready) begin s_wbase = awaddr >> 2; s_wlen = awlen; s_wcnt = 0; end
    if (wr_valid && wr_ready) src_idx++;
    if (e_w && wr_valid && wready) begin
      cap_w.push_back(wdata);
      if (wlast) cap_wlast.push_back(beats);
      if (beats == c_len) data_done = 1;
      beats++;
    end
    if (wvalid && wready) begin
      mem[(s_wbase + s_wcnt) & 63] = wdata;
      s_wcnt++;
      if (s_wcnt > s_wlen) s_bpend = 1;
    end
    if (e_b && s_bv) begin exp_resp = inj_bresp; busy = 0; done_due = 1; end
    if (s_bv && bready) begin s_bv = 0; s_bpend = 0; end
    if (e_ar && arready) a_done = 1;
    if (arvalid && arready) begin s_ract = 1; s_rbase = araddr >> 2; s_rlen = arlen; s_rcnt = 0; end
    if (e_r && s_rv && rd_ready) begin
      cap_rd.push_back(rd_data);
      if (rd_last) cap_rlast.push_back(beats);
      chk("rd_mem", rd_data, ref_mem[((c_addr >> 2) + beats) & 63]);
      if (rresp > exp_resp) exp_resp = rresp;
      if (rlast != (beats == c_len)) exp_err = 1;
      if (beats == c_len) begin busy = 0; done_due = 1; end
      beats++;
    end
    if (s_rv && rready) begin
      s_rv = 0; s_rcnt++;
      if (s_rcnt > s_rlen) s_ract = 0;
    end
    if (!was_busy && cmd_valid) begin
      busy = 1; c_write = p_write; c_addr = p_addr; c_len = p_len; c_id = p_id;
      a_done = 0; data_done = 0; beats = 0; exp_resp = '0; exp_err = 0;
      pend_cmd = 0; acc_cyc = cyc;
    end
  endtask

  task automatic start_cmd(input bit wr, input int waddr, input int len, input bit pat);
    logic [31:0] d;
    p_write = wr; p_addr = 8'(waddr * 4); p_len = 8'(len); p_id = 8'($urandom);
    src_q.delete(); src_idx = 0;
    cap_w.delete(); cap_rd.delete(); cap_wlast.delete(); cap_rlast.delete();
    cap_awlen = -1; done_cyc = -1;
    if (wr)
      for (int i = 0; i <= len; i++) begin
        d = pat ? 32'hDEADBEEF + 32'(i) : $urandom;
        src_q.push_back(d);
        ref_mem[(waddr + i) & 63] = d;
      end
    pend_cmd = 1;
  endtask

  task automatic wait_cmd();
    int n = 0;
    do begin tick(); n++; end while ((pend_cmd || busy) && n < 3000);
    if (pend_cmd || busy) begin
      n_vec++; n_err++;
      $display("FAIL cmd_timeout: command still open after %0d cycles, expected completion", n);
      pend_cmd = 0;
    end
  endtask

  task automatic run_cmd(input bit wr, input int waddr, input int len, input bit pat);
    start_cmd(wr, waddr, len, pat);
    wait_cmd();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    int len, wa;
    base = 32'hDEADBEEF;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    #12;
    chk("rst_cmd_ready", cmd_ready, 0); chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0); chk("rst_bready", bready, 0);
    chk("rst_done", done, 0); chk("rst_done_resp", done_resp, 0); chk("rst_done_err", done_err, 0);
    chk("rst_awaddr", awaddr, 0); chk("rst_awlen", awlen, 0); chk("rst_awid", awid, 0);
    chk("tie_lock", {awlock, arlock}, 0); chk("tie_cache", {awcache, arcache}, 0);
    chk("tie_prot", {awprot, arprot}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Zero-wait write then read of DEADBEEF+i at address 0
    run_cmd(1, 0, 3, 1); tick();
    chk("t1_awlen", cap_awlen, 3);
    chk("t1_beats", cap_w.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_wdata", cap_w[i], base + 32'(i));
    chk("t1_wlast_cnt", cap_wlast.size(), 1);
    chk("t1_wlast_pos", cap_wlast[0], 3);
    chk("t1_latency", done_cyc - acc_cyc, 7);
    chk("t1_resp", seen_resp, 0); chk("t1_err", seen_err, 0);
    run_cmd(0, 0, 3, 0); tick();
    chk("t2_beats", cap_rd.size(), 4);
    for (int i = 0; i < 4; i++) chk("t2_rdata", cap_rd[i], base + 32'(i));
    chk("t2_rlast_cnt", cap_rlast.size(), 1);
    chk("t2_rlast_pos", cap_rlast[0], 3);
    chk("t2_err", seen_err, 0);

    // Single-beat bursts
    run_cmd(1, 20, 0, 0); tick();
    chk("len0_wlast", cap_wlast.size() == 1 && cap_wlast[0] == 0, 1);
    chk("len0_latency", done_cyc - acc_cyc, 4);
    run_cmd(0, 20, 0, 0); tick();
    chk("len0_rlast", cap_rlast.size() == 1 && cap_rlast[0] == 0, 1);

    // Error responses and early rlast
    inj_bresp = 2'd2;
    run_cmd(1, 8, 2, 0); tick();
    chk("t4_bresp", seen_resp, 2);
    inj_bresp = 2'd0; inj_rbeat = 1;
    run_cmd(0, 8, 2, 0); tick();
    chk("t4_rresp", seen_resp, 2);
    inj_rbeat = -1; early_last = 1;
    run_cmd(0, 0, 3, 0); tick();
    chk("t5_err", seen_err, 1);
    chk("t5_beats", cap_rd.size(), 4);
    early_last = -1;

    // Random stalls and gaps, back-to-back commands
    p_slv = 60; p_src = 60; p_sink = 50;
    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(15, 0);
      wa  = $urandom_range(63 - len, 0);
      run_cmd($urandom_range(1, 0), wa, len, 0);
    end
    tick();

    // Reset in the middle of a write burst
    p_slv = 100; p_src = 100; p_sink = 100;
    start_cmd(1, 32, 15, 0);
    for (int n = 0; n < 200 && beats < 3; n++) tick();
    #2; rst_n = 1'b0; #1;
    chk("rst6_awvalid", awvalid, 0); chk("rst6_wvalid", wvalid, 0);
    chk("rst6_wr_ready", wr_ready, 0); chk("rst6_bready", bready, 0);
    chk("rst6_arvalid", arvalid, 0); chk("rst6_rready", rready, 0);
    chk("rst6_rd_valid", rd_valid, 0); chk("rst6_cmd_ready", cmd_ready, 0);
    chk("rst6_done", done, 0);
    busy = 0; pend_cmd = 0; done_due = 0; a_done = 0; data_done = 0;
    s_bpend = 0; s_bv = 0; s_ract = 0; s_rv = 0;
    src_q.delete(); src_idx = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    @(negedge clk); rst_n = 1'b1;
    run_cmd(1, 40, 5, 0);
    run_cmd(0, 40, 5, 0); tick();
    chk("t6_beats", cap_rd.size(), 6);
    chk("t6_err", seen_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
